counter_gen2: RTL and testbench

Parametrised, prescaled up/down counter with selectable run mode (wrap, saturate, one-shot, auto-reload), synchronous load, compare-match and terminal-count pulses. It is the successor to the fixed-width free-running counter. It sits behind the tile top level, which drives `ui_in`/`uio_in` into its control inputs and routes `count`/flags to `uo_out`/`uio_out`.

---
 rtl/counter_gen2_pkg.sv | 27 ++
 rtl/counter_prescaler.sv | 49 ++++
 rtl/counter_gen2.sv | 170 +++++++++++++++++
 tb/tb_counter_gen2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_gen2_pkg.sv
// counter_gen2_pkg
//   Shared types and constants for the counter_gen2 block.
//   - mode_e  : run-mode selection, encoded exactly as the `mode` input bits.
//   - state_e : counter control states.
//   Build option: COUNTER_GEN2_PWM_EN (used by counter_gen2) adds a pwm output.
package counter_gen2_pkg;

  // Raw encodings of the 2-bit `mode` input.
  localparam logic [1:0] MODE_ENC_WRAP    = 2'b00;
  localparam logic [1:0] MODE_ENC_SAT     = 2'b01;
  localparam logic [1:0] MODE_ENC_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_ENC_RELOAD  = 2'b11;

  typedef enum logic [1:0] {
    MODE_WRAP    = MODE_ENC_WRAP,
    MODE_SAT     = MODE_ENC_SAT,
    MODE_ONESHOT = MODE_ENC_ONESHOT,
    MODE_RELOAD  = MODE_ENC_RELOAD
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Divides enabled cycles down to a one-cycle `tick`: tick fires on every
//   (prescale+1)-th enabled cycle. Comparison is >= so that lowering
//   `prescale` below the current internal count fires a tick at once.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous reset, active-high
//   en       in  count this cycle (global enable AND counter running)
//   clear    in  restart the division from zero (start/load)
//   prescale in  divide ratio minus one
//   tick     out prescaler terminal this cycle (combinational)
module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] presc_r;
  logic                  at_end_s;

  assign at_end_s = (presc_r >= prescale);
  assign tick     = en & ~clear & at_end_s;

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= PRE_ZERO;
    end else if (clear) begin
      presc_r <= PRE_ZERO;
    end else if (en) begin
      if (at_end_s) begin
        presc_r <= PRE_ZERO;
      end else begin
        presc_r <= presc_r + PRE_ONE;
      end
    end else begin
      presc_r <= presc_r;
    end
  end

endmodule

// File: rtl/counter_gen2.sv
// counter_gen2
//   Prescaled up/down counter with wrap / saturate / one-shot / auto-reload
//   modes, synchronous load, terminal-count and compare-match pulses.
//   Per-cycle priority: rst > load > stop > start > tick.
//   Build option: define COUNTER_GEN2_PWM_EN to add the `pwm` output.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              global enable (low freezes everything but reset)
//   start, stop     enter RUN / return to IDLE
//   load, load_val  synchronous load; load_val is also the reload value
//   dir             0 = up, 1 = down
//   mode            run mode (see counter_gen2_pkg::mode_e)
//   prescale        tick every prescale+1 enabled cycles
//   cmp_val         compare value for `match`
//   count           current count (registered)
//   tc, match       one-cycle terminal-count and compare-match pulses
//   running, done   state == RUN / state == DONE
//   pwm (optional)  count < cmp_val while running
module counter_gen2
  import counter_gen2_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  match,
  output logic                  running,
  output logic                  done
`ifdef COUNTER_GEN2_PWM_EN
  ,
  output logic                  pwm
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_r, next_state_s;
  logic [WIDTH-1:0] count_r, next_count_s;
  logic [WIDTH-1:0] term_s, step_s, tick_val_s;
  logic             tc_r, match_r, running_r, done_r;
  logic             tc_s, match_s;
  logic             tick_s, tick_effect_s;
  logic             start_acc_s, presc_en_s, presc_clear_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // A start only counts when nothing of higher priority is present and we
  // are not already running.
  assign start_acc_s   = start & ~stop & ~load & (state_r != ST_RUN);
  assign presc_en_s    = en & (state_r == ST_RUN);
  assign presc_clear_s = en & (load | start_acc_s);

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (presc_en_s),
    .clear    (presc_clear_s),
    .prescale (prescale),
    .tick     (tick_s)
  );

  assign term_s = dir ? ALL_ZERO : ALL_ONES;
  assign step_s = dir ? (count_r - ONE) : (count_r + ONE);

  // Value a tick would produce, including the behaviour at the terminal value.
  always_comb begin
    tick_val_s    = step_s;
    tick_effect_s = 1'b1;
    if (count_r == term_s) begin
      case (mode_s)
        MODE_SAT: begin
          tick_val_s    = count_r;
          tick_effect_s = 1'b0;
        end
        MODE_RELOAD: tick_val_s = load_val;
        // Wrap, and one-shot restarted while sitting on T, both roll over.
        default:     tick_val_s = step_s;
      endcase
    end else begin
      tick_val_s = step_s;
    end
  end

  // Next-state, next-count and pulse decode in priority order.
  always_comb begin
    next_count_s = count_r;
    next_state_s = state_r;
    tc_s         = 1'b0;
    match_s      = 1'b0;
    if (!en) begin
      next_count_s = count_r;
    end else if (load) begin
      next_count_s = load_val;
      match_s      = (load_val == cmp_val);
    end else if (stop) begin
      next_state_s = ST_IDLE;
    end else if (start_acc_s) begin
      next_state_s = ST_RUN;
    end else if (tick_s && tick_effect_s) begin
      next_count_s = tick_val_s;
      tc_s         = (tick_val_s == term_s);
      match_s      = (tick_val_s == cmp_val);
      if ((mode_s == MODE_ONESHOT) && (tick_val_s == term_s)) begin
        next_state_s = ST_DONE;
      end else begin
        next_state_s = state_r;
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= ALL_ZERO;
      tc_r      <= 1'b0;
      match_r   <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      count_r   <= next_count_s;
      tc_r      <= tc_s;
      match_r   <= match_s;
      running_r <= (next_state_s == ST_RUN);
      done_r    <= (next_state_s == ST_DONE);
    end
  end

  assign count   = count_r;
  assign tc      = tc_r;
  assign match   = match_r;
  assign running = running_r;
  assign done    = done_r;

`ifdef COUNTER_GEN2_PWM_EN
  logic pwm_r;

  // PWM compare, aligned with the count value it is registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= (next_state_s == ST_RUN) && (next_count_s < cmp_val);
    end
  end

  assign pwm = pwm_r;
`endif

endmodule

// File: tb/tb_counter_gen2.sv
// tb_counter_gen2
//   Self-checking bench for counter_gen2 (WIDTH=8, PRESCALE_W=4): a directed
//   vector table, hand-written multi-cycle sequences, and a randomized phase,
//   all cross-checked every cycle against a behavioural reference model.
module tb_counter_gen2;

  localparam int W    = 8;
  localparam int PW   = 4;
  localparam int MAXV = 255;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = 8'd0;
  logic          dir = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [PW-1:0] prescale = 4'd0;
  logic [W-1:0]  cmp_val = 8'd0;
  logic [W-1:0]  count;
  logic          tc, match, running, done;
`ifdef COUNTER_GEN2_PWM_EN
  logic          pwm;
`endif

  always #5 clk = ~clk;

  counter_gen2 #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .prescale (prescale),
    .cmp_val  (cmp_val),
    .count    (count),
    .tc       (tc),
    .match    (match),
    .running  (running),
    .done     (done)
`ifdef COUNTER_GEN2_PWM_EN
    ,
    .pwm      (pwm)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers).
  int m_count = 0;
  int m_presc = 0;
  int m_state = S_IDLE;
  int m_tc    = 0;
  int m_match = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int  term;
    int  nc;
    bit  tick;
    bit  eff;
    if (rst) begin
      m_count = 0; m_presc = 0; m_state = S_IDLE; m_tc = 0; m_match = 0;
    end else if (!en) begin
      m_tc = 0; m_match = 0;
    end else begin
      m_tc = 0; m_match = 0;
      term = dir ? 0 : MAXV;
      tick = (m_state == S_RUN) && (m_presc >= int'(prescale));
      if (m_state == S_RUN) m_presc = tick ? 0 : m_presc + 1;
      if (load) begin
        m_count = int'(load_val);
        m_presc = 0;
        m_match = (load_val == cmp_val) ? 1 : 0;
      end else if (stop) begin
        m_state = S_IDLE;
      end else if (start && m_state != S_RUN) begin
        m_state = S_RUN;
        m_presc = 0;
      end else if (tick) begin
        eff = 1'b1;
        nc  = (m_count + (dir ? MAXV : 1)) % (MAXV + 1);
        if (m_count == term) begin
          if (mode == 2'b01) begin
            nc = m_count; eff = 1'b0;
          end else if (mode == 2'b11) begin
            nc = int'(load_val);
          end
        end
        if (eff) begin
          m_count = nc;
          m_tc    = (nc == term) ? 1 : 0;
          m_match = (nc == int'(cmp_val)) ? 1 : 0;
          if (mode == 2'b10 && nc == term) m_state = S_DONE;
        end
      end
    end
  endtask

  // One clock: model follows the edge, then all DUT outputs are compared.
  task automatic step();
    int act, exp;
    @(posedge clk);
    model_step();
    #1;
    act = (int'(count) << 4) | (int'(tc) << 3) | (int'(match) << 2) | (int'(running) << 1) | int'(done);
    exp = (m_count << 4) | (m_tc << 3) | (m_match << 2) |
          ((m_state == S_RUN) ? 2 : 0) | ((m_state == S_DONE) ? 1 : 0);
    check("model{count,tc,match,running,done}", act, exp);
  endtask

  typedef struct {
    logic         en, rst, start, stop, load;
    logic [7:0]   lv;
    logic         dir;
    logic [1:0]   mode;
    logic [7:0]   cmp;
    int           e_count;
    bit           e_tc, e_match, e_run, e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, r, s, p, l, input logic [7:0] lv,
                              input logic d, input logic [1:0] md, input logic [7:0] c,
                              input int ec, input bit et, em, er, ed);
    vec_t v;
    v.en = e; v.rst = r; v.start = s; v.stop = p; v.load = l; v.lv = lv;
    v.dir = d; v.mode = md; v.cmp = c;
    v.e_count = ec; v.e_tc = et; v.e_match = em; v.e_run = er; v.e_done = ed;
    return v;
  endfunction

  int exp_seq[14] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};

  initial begin
    // en rst st sp ld lv d md cmp | count tc m run done
    vecs.push_back(mk(1,1,0,0,0,  0,0,2'd0,  0,   0,0,0,0,0)); // reset
    vecs.push_back(mk(1,1,0,0,0,  0,0,2'd0,  0,   0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,  5,1,2'd2,  3,   5,0,0,0,0)); // one-shot down, load 5
    vecs.push_back(mk(1,0,1,0,0,  5,1,2'd2,  3,   5,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3,   4,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3,   3,0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3,   2,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3,   1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3,   0,1,0,0,1)); // tc, DONE
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3,   0,0,0,0,1));
    vecs.push_back(mk(1,0,1,0,0,  5,1,2'd2,  3,   0,0,0,1,0)); // restart from 0
    vecs.push_back(mk(1,0,0,0,0,  5,1,2'd2,  3, 255,0,0,1,0)); // wraps to 255
    vecs.push_back(mk(1,0,0,1,0,  5,1,2'd2,  3, 255,0,0,0,0)); // stop beats tick
    vecs.push_back(mk(1,0,0,0,1,253,0,2'd0,254, 253,0,0,0,0)); // wrap up
    vecs.push_back(mk(1,0,1,0,0,253,0,2'd0,254, 253,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,253,0,2'd0,254, 254,0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,253,0,2'd0,254, 255,1,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,253,0,2'd0,254,   0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,253,0,2'd0,254,   1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,1,100,0,2'd0,254, 100,0,0,1,0)); // load beats tick
    vecs.push_back(mk(1,0,0,0,0,100,0,2'd0,254, 101,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,1,254,0,2'd1,254, 254,0,1,1,0)); // saturate
    vecs.push_back(mk(1,0,0,0,0,254,0,2'd1,254, 255,1,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,254,0,2'd1,254, 255,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,254,0,2'd1,254, 255,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 250,0,0,1,0)); // auto-reload
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 251,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 252,0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 253,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 254,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 255,1,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 250,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,250,0,2'd3,252, 250,0,0,1,0)); // en low freezes
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252, 251,0,0,1,0));
    vecs.push_back(mk(1,1,0,0,0,250,0,2'd3,252,   0,0,0,0,0)); // reset
    vecs.push_back(mk(1,0,0,0,0,250,0,2'd3,252,   0,0,0,0,0));

    foreach (vecs[i]) begin
      en = vecs[i].en; rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      load = vecs[i].load; load_val = vecs[i].lv; dir = vecs[i].dir;
      mode = vecs[i].mode; cmp_val = vecs[i].cmp; prescale = 4'd0;
      step();
      check($sformatf("vec%0d.count", i), int'(count), vecs[i].e_count);
      check($sformatf("vec%0d.tc", i), int'(tc), int'(vecs[i].e_tc));
      check($sformatf("vec%0d.match", i), int'(match), int'(vecs[i].e_match));
      check($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].e_run));
      check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].e_done));
    end

    // prescale=3: increments every 4 cycles, en gap delays by 2.
    rst = 1'b0; en = 1'b1; load = 1'b0; stop = 1'b0;
    mode = 2'b00; dir = 1'b0; prescale = 4'd3; cmp_val = 8'd200;
    start = 1'b1;
    step();
    check("presc.running", int'(running), 1);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      en = (k == 8 || k == 9) ? 1'b0 : 1'b1;
      step();
      check($sformatf("presc.count_e%0d", k + 1), int'(count), exp_seq[k]);
    end
    en = 1'b1;

    // Lowering prescale below the current prescaler value ticks next cycle.
    stop = 1'b1;
    step();
    stop = 1'b0;
    prescale = 4'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("lower.hold", int'(count), 3);
    end
    prescale = 4'd2;
    step();
    check("lower.tick_now", int'(count), 4);
    step();
    step();
    check("lower.after_e8", int'(count), 4);
    step();
    check("lower.after_e9", int'(count), 5);

    // Reset while a tc is pending.
    prescale = 4'd0;
    load = 1'b1; load_val = 8'd254; cmp_val = 8'd255;
    step();
    load = 1'b0;
    rst = 1'b1;
    step();
    check("rst.count", int'(count), 0);
    check("rst.tc", int'(tc), 0);
    check("rst.match", int'(match), 0);
    check("rst.running", int'(running), 0);
    step();
    check("rst.hold_count", int'(count), 0);
    rst = 1'b0;
    step();
    check("rst.after_count", int'(count), 0);
    check("rst.after_running", int'(running), 0);

    // Randomized phase, checked against the model in step().
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0)
        prescale = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: load_val = 8'd0;
          1: load_val = 8'd1;
          2: load_val = 8'd254;
          3: load_val = 8'd255;
          default: load_val = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 31) == 0) cmp_val = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
